pb_add_sequencer: RTL and testbench
===================================

# pb_add_sequencer

Pushbutton-driven controller that sequences a single 1-bit full adder over multiple cycles to form a multi-bit sum with carry-out. It takes the lab board's five pushbuttons and 4-bit switch bank, synchronises and edge-detects the buttons, latches operands, and runs a bit-serial add or accumulate. The result appears on the 6-bit `sum` / `cout` display outputs. It replaces the combinational button-to-adder path with a clocked, reset-able control block.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `WIDTH`, default 4: switch operand width.
- `SYNC_STAGES`, default 2: synchroniser flops per pushbutton, minimum 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pb1`  in  1  raw button: load operand A from `y`.
- `pb2`  in  1  raw button: load operand B from `y`.
- `pb3`  in  1  raw button: start add, `sum` = A + B.
- `pb4`  in  1  raw button: accumulate, `sum` = `sum` + B.
- `pb5`  in  1  raw button: clear.
- `y`  in  WIDTH  switch operand; sampled only on a load action.
- `sum`  out  WIDTH+2  result register.
- `cout`  out  1  carry out of bit WIDTH+1 of the last add.
- `busy`  out  1  high while an add is in progress.
- `done`  out  1  one-cycle pulse when `sum`/`cout` update.

## Operation
- Each pb passes through SYNC_STAGES flops, then one more flop; action pulse = synced & ~delayed (rising edge only). Holding a button gives one action.
- Operands A and B are WIDTH+2 bits wide. Loads zero-extend `y`.
- States:
  - IDLE: accepts actions.
  - ADD: serial add in progress.
  - DONE: one cycle, publishes the result.
- Action priority in IDLE:
  - pb5 overrides all: A, B, `sum`, `cout` and the carry register go to 0; stay in IDLE.
  - pb1 and pb2 may act in the same cycle; both loads occur.
  - Any load in a cycle suppresses a pb3/pb4 in that cycle; the suppressed start is dropped, not queued.
  - pb3 beats pb4.
- pb3 start: operand X ← A; carry ← 0; bit index ← 0; go to ADD.
- pb4 start: operand X ← current `sum`; carry ← 0; go to ADD.
- ADD, once per cycle:
  - Full adder takes X[i], B[i] and carry.
  - The sum bit shifts into a WIDTH+2 result shift register; carry updates.
  - i increments.
  - After bit WIDTH+1, go to DONE.
- DONE: `sum` ← shift register; `cout` ← final carry; `done` = 1; go to IDLE unconditionally.
- In ADD or DONE: pb1–pb4 actions are ignored and dropped. A pb5 action aborts: clear as in IDLE, `busy` drops, no `done`, return to IDLE.
- Arithmetic is modulo 2^(WIDTH+2); overflow is reported only on `cout`. `sum` is never partially updated.

## Timing
- Reset values: `sum`=0, `cout`=0, `busy`=0, `done`=0, A=B=0, state IDLE, synchroniser flops 0.
- Button-to-action latency: the action takes effect on the (SYNC_STAGES+2)th rising edge after the pb is first sampled high.
- `busy` is high from the edge that enters ADD through the DONE cycle inclusive.
- Add latency: WIDTH+2 cycles in ADD, plus 1 DONE cycle. `done`, new `sum` and new `cout` are visible together.
- The first IDLE cycle after DONE accepts new actions.
- Reset asserted mid-add: immediate return to reset values; no `done`.

## Structure
- Package `pb_add_pkg`:
  - state enum {IDLE, ADD, DONE};
  - default WIDTH and SYNC_STAGES constants;
  - bit-index width function clog2(WIDTH+2).
- Sub-module `full_adder` (a, b, cin → s, cout), purely combinational, instantiated once.
- The synchroniser/edge detector is a generate loop over the 5 buttons, not a separate module.

## Test plan
- Reset, then pb1 with y=15, pb2 with y=15, then pb3 → after WIDTH+3 cycles `done` pulses, `sum`=6'b011110 (30), `cout`=0.
- Continuing from 30, pb4 ×3, each after the previous `done` → `sum` 45, 60, then 11 with `cout`=1 (75 mod 64).
- pb1 held high 50 cycles with y=8 → A loads exactly once; then B=1 and pb3 → `sum`=9.
- pb3 pressed during ADD → ignored: a single `done`, unchanged result; pb5 during ADD → `busy` drops next edge, `sum`=0, no `done`.
- pb1 and pb3 actions in the same cycle → A loads, no add starts, `busy` stays 0.
- `rst_n` pulsed low mid-ADD → all outputs 0 immediately (asynchronous); a subsequent pb3 computes 0+0 → `sum`=0, `cout`=0.

Source files
------------

// File: rtl/pb_add_pkg.sv
// pb_add_pkg: shared state encoding, default sizing and index-width helper
package pb_add_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int idx_w(input int width);
    return $clog2(width + 2);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pb_add_sequencer.sv
// pb_add_sequencer: pushbutton-driven bit-serial add/accumulate controller
// around one full adder; results publish atomically with a done pulse.
module pb_add_sequencer
  import pb_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb1,
  input  logic             pb2,
  input  logic             pb3,
  input  logic             pb4,
  input  logic             pb5,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH+1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int W = WIDTH + 2;
  localparam int IW = idx_w(WIDTH);
  logic [4:0] pb_raw, act;
  assign pb_raw = {pb5, pb4, pb3, pb2, pb1};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    logic [SYNC_STAGES:0] sh_q, sh_d;
    logic act_q, act_d;
    // top bit is the extra delay flop used for rising-edge detection
    always_comb begin
      sh_d = {sh_q[SYNC_STAGES-1:0], pb_raw[i]};
      act_d = sh_q[SYNC_STAGES-1] & ~sh_q[SYNC_STAGES];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_q <= '0;
        act_q <= 1'b0;
      end else begin
        sh_q <= sh_d;
        act_q <= act_d;
      end
    end
    assign act[i] = act_q;
  end
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, x_q, x_d, sr_q, sr_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic [IW-1:0] idx_q, idx_d;
  logic fa_s, fa_co;
  full_adder u_fa (
    .a   (x_q[idx_q]),
    .b   (b_q[idx_q]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_co)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    x_d = x_q;
    sr_d = sr_q;
    carry_d = carry_q;
    idx_d = idx_q;
    sum_d = sum_q;
    cout_d = cout_q;
    done_d = 1'b0;
    if (act[4]) begin
      a_d = '0;
      b_d = '0;
      sum_d = '0;
      cout_d = 1'b0;
      carry_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          a_d = act[0] ? W'(y) : a_q;
          b_d = act[1] ? W'(y) : b_q;
          // a load in the same cycle drops any start request
          if (!(act[0] | act[1]) && (act[2] | act[3])) begin
            x_d = act[2] ? a_q : sum_q;
            carry_d = 1'b0;
            idx_d = '0;
            state_d = ADD;
          end
        end
        ADD: begin
          sr_d = {fa_s, sr_q[W-1:1]};
          carry_d = fa_co;
          idx_d = idx_q + 1'b1;
          state_d = (idx_q == IW'(W - 1)) ? DONE : ADD;
        end
        DONE: begin
          sum_d = sr_q;
          cout_d = carry_q;
          done_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      x_q <= '0;
      sr_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      x_q <= x_d;
      sr_q <= sr_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      done_q <= done_d;
    end
  end
  assign sum = sum_q;
  assign cout = cout_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_pb_add_sequencer.sv
// tb_pb_add_sequencer: randomized and directed checks of pb_add_sequencer
// against an arithmetic model of operands, sum and carry-out.
module tb_pb_add_sequencer;
  localparam int WIDTH = 4;
  localparam int SS = 2;
  localparam int W = WIDTH + 2;
  localparam int MOD = 1 << W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] pb = '0;
  logic [WIDTH-1:0] y = '0;
  logic [W-1:0] sum;
  logic cout, busy, done;
  int vecs = 0;
  int errs = 0;
  int ma = 0, mb = 0, ms = 0, mc = 0;
  always #5 clk = ~clk;
  pb_add_sequencer #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .pb1(pb[0]), .pb2(pb[1]), .pb3(pb[2]), .pb4(pb[3]), .pb5(pb[4]),
    .y(y), .sum(sum), .cout(cout), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load(input int b, input int val);
    int h;
    h = $urandom_range(1, 3);
    y = WIDTH'(val);
    pb[b] = 1'b1;
    repeat (h) @(negedge clk);
    pb[b] = 1'b0;
    repeat (6) @(negedge clk);
    if (b == 0) ma = val; else mb = val;
    chk("load_busy", 32'(busy), 0);
  endtask
  task automatic run(input int b);
    int h, fb, lat, e;
    h = $urandom_range(1, 3);
    fb = -1;
    lat = -1;
    e = ((b == 2) ? ma : ms) + mb;
    pb[b] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == h) pb[b] = 1'b0;
      if (busy && fb < 0) fb = k;
      if (done) begin
        lat = k;
        break;
      end
    end
    pb[b] = 1'b0;
    chk("busy_latency", 32'(fb), 32'(SS + 2));
    chk("done_latency", 32'(lat), 32'(SS + 2 + W + 1));
    chk("sum", 32'(sum), 32'(e % MOD));
    chk("cout", 32'(cout), 32'(e >= MOD));
    chk("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    ms = e % MOD;
    mc = (e >= MOD) ? 1 : 0;
  endtask
  task automatic clr();
    pb[4] = 1'b1;
    @(negedge clk);
    pb[4] = 1'b0;
    repeat (6) @(negedge clk);
    ma = 0; mb = 0; ms = 0; mc = 0;
    chk("clr_sum", 32'(sum), 0);
    chk("clr_cout", 32'(cout), 0);
    chk("clr_busy", 32'(busy), 0);
  endtask
  initial begin
    int nd, bs, v;
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    load(0, 15);
    load(1, 15);
    run(2);
    chk("dir_30", 32'(sum), 30);
    repeat (3) run(3);
    chk("dir_11", 32'(sum), 11);
    chk("dir_c1", 32'(cout), 1);
    y = 4'd8;
    pb[0] = 1'b1;
    repeat (10) @(negedge clk);
    y = 4'd3;
    repeat (40) @(negedge clk);
    pb[0] = 1'b0;
    repeat (6) @(negedge clk);
    ma = 8;
    load(1, 1);
    run(2);
    chk("hold_once", 32'(sum), 9);
    nd = 0;
    pb[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) pb[2] = 1'b0;
      if (k == 5) pb[2] = 1'b1;
      if (k == 6) pb[2] = 1'b0;
      nd += 32'(done);
    end
    chk("ign_done_cnt", 32'(nd), 1);
    chk("ign_sum", 32'(sum), 9);
    nd = 0;
    pb[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) pb[2] = 1'b0;
      if (k == 5) pb[4] = 1'b1;
      if (k == 6) pb[4] = 1'b0;
      if (k == 8) chk("abort_busy_pre", 32'(busy), 1);
      if (k == 9) chk("abort_busy_post", 32'(busy), 0);
      nd += 32'(done);
    end
    ma = 0; mb = 0; ms = 0; mc = 0;
    chk("abort_done_cnt", 32'(nd), 0);
    chk("abort_sum", 32'(sum), 0);
    v = $urandom_range(1, 15);
    y = WIDTH'(v);
    pb[0] = 1'b1;
    pb[2] = 1'b1;
    repeat (2) @(negedge clk);
    pb[0] = 1'b0;
    pb[2] = 1'b0;
    bs = 0;
    repeat (20) begin
      @(negedge clk);
      bs |= 32'(busy);
    end
    chk("same_cycle_busy", 32'(bs), 0);
    ma = v;
    load(1, 5);
    run(2);
    chk("same_cycle_sum", 32'(sum), 32'(v + 5));
    pb[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) pb[2] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 0);
    chk("arst_cout", 32'(cout), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ma = 0; mb = 0; ms = 0; mc = 0;
    @(negedge clk);
    run(2);
    chk("arst_add", 32'(sum), 0);
    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(0, 9);
      if (v <= 2) load(0, $urandom_range(0, 15));
      else if (v <= 4) load(1, $urandom_range(0, 15));
      else if (v <= 6) run(2);
      else if (v <= 8) run(3);
      else clr();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
